// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// opcodes, ALU codes, datapath selects and FSM state.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_R31 = 2'b10;

  localparam logic [1:0] WD_C  = 2'b00;
  localparam logic [1:0] WD_DR = 2'b01;
  localparam logic [1:0] WD_PC = 2'b10;

  localparam logic [1:0] A_RD1   = 2'b00;
  localparam logic [1:0] A_C16   = 2'b01;
  localparam logic [1:0] A_SHAMT = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_ALUR, C_ALUI, C_LW, C_SW,
    C_BEQ,  C_J,    C_JR, C_JAL
  } cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational Op/Funct decode into instruction class
// and the ALU-side selects used from EXE onward.
module mc_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 5
) (
  input  logic [OPW-1:0]    i_op,
  input  logic [OPW-1:0]    i_funct,
  output cls_e              o_cls,
  output logic [ALUOPW-1:0] o_aluop,
  output logic [1:0]        o_asel,
  output logic              o_bsel,
  output logic [1:0]        o_extop,
  output logic              o_legal
);

  always_comb begin
    o_cls   = C_ALUR;
    o_aluop = ALU_ADDU;
    o_asel  = A_RD1;
    o_bsel  = 1'b0;
    o_extop = EXT_ZERO;
    o_legal = 1'b0;
    unique case (1'b1)
      (i_op == OP_RTYPE): begin
        unique case (1'b1)
          (i_funct == F_ADDU): begin
            o_legal = 1'b1;
          end
          (i_funct == F_SUBU): begin
            o_aluop = ALU_SUBU;
            o_legal = 1'b1;
          end
          (i_funct == F_AND): begin
            o_aluop = ALU_AND;
            o_legal = 1'b1;
          end
          (i_funct == F_OR): begin
            o_aluop = ALU_OR;
            o_legal = 1'b1;
          end
          (i_funct == F_SLT): begin
            o_aluop = ALU_SLT;
            o_legal = 1'b1;
          end
          (i_funct == F_SLL): begin
            o_aluop = ALU_SLL;
            o_asel  = A_SHAMT;
            o_legal = 1'b1;
          end
          (i_funct == F_SRL): begin
            o_aluop = ALU_SRL;
            o_asel  = A_SHAMT;
            o_legal = 1'b1;
          end
          (i_funct == F_JR): begin
            o_cls   = C_JR;
            o_legal = 1'b1;
          end
          default: ;
        endcase
      end
      (i_op == OP_ADDIU): begin
        o_cls   = C_ALUI;
        o_bsel  = 1'b1;
        o_extop = EXT_SIGN;
        o_legal = 1'b1;
      end
      (i_op == OP_ORI): begin
        o_cls   = C_ALUI;
        o_aluop = ALU_OR;
        o_bsel  = 1'b1;
        o_legal = 1'b1;
      end
      (i_op == OP_LUI): begin
        // imm shifted left by the constant 16
        o_cls   = C_ALUI;
        o_aluop = ALU_SLL;
        o_asel  = A_C16;
        o_bsel  = 1'b1;
        o_legal = 1'b1;
      end
      (i_op == OP_LW): begin
        o_cls   = C_LW;
        o_bsel  = 1'b1;
        o_extop = EXT_SIGN;
        o_legal = 1'b1;
      end
      (i_op == OP_SW): begin
        o_cls   = C_SW;
        o_bsel  = 1'b1;
        o_extop = EXT_SIGN;
        o_legal = 1'b1;
      end
      (i_op == OP_BEQ): begin
        o_cls   = C_BEQ;
        o_aluop = ALU_SUBU;
        o_extop = EXT_SIGN;
        o_legal = 1'b1;
      end
      (i_op == OP_J): begin
        o_cls   = C_J;
        o_legal = 1'b1;
      end
      (i_op == OP_JAL): begin
        o_cls   = C_JAL;
        o_legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXE/MEM/WB
// with memory-ready stalls and illegal-opcode flagging.
module mc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    Op,
  input  logic [OPW-1:0]    Funct,
  input  logic              Zero,
  input  logic              mem_ready,
  output logic              RFWr,
  output logic              DMWr,
  output logic              PCWr,
  output logic              IRWr,
  output logic [1:0]        EXTOp,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [1:0]        NPCOp,
  output logic [1:0]        GPRSel,
  output logic [1:0]        WDSel,
  output logic [1:0]        ASel,
  output logic              BSel,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              illegal
);

  state_e              r_state;
  cls_e                r_cls;
  logic [ALUOPW-1:0]   r_aluop;
  logic [1:0]          r_asel;
  logic                r_bsel;
  logic [1:0]          r_extop;

  state_e              w_next;
  cls_e                w_cls;
  logic [ALUOPW-1:0]   w_aluop;
  logic [1:0]          w_asel;
  logic                w_bsel;
  logic [1:0]          w_extop;
  logic                w_legal;

  mc_decode #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_dec (
    .i_op    (Op),
    .i_funct (Funct),
    .o_cls   (w_cls),
    .o_aluop (w_aluop),
    .o_asel  (w_asel),
    .o_bsel  (w_bsel),
    .o_extop (w_extop),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_cls   <= C_ALUR;
      r_aluop <= '0;
      r_asel  <= '0;
      r_bsel  <= 1'b0;
      r_extop <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls   <= w_cls;
        r_aluop <= w_aluop;
        r_asel  <= w_asel;
        r_bsel  <= w_bsel;
        r_extop <= w_extop;
      end
    end
  end

  assign state = r_state;

  // Everything stays quiet while rst is low, even mid-stall
  always_comb begin
    w_next     = S_FETCH;
    RFWr       = 1'b0;
    DMWr       = 1'b0;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    EXTOp      = '0;
    ALUOp      = '0;
    NPCOp      = NPC_PC4;
    GPRSel     = GPR_RD;
    WDSel      = WD_C;
    ASel       = A_RD1;
    BSel       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          IRWr   = mem_ready;
          PCWr   = mem_ready;
          w_next = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          illegal = !w_legal;
          w_next  = w_legal ? S_EXE : S_FETCH;
        end
        S_EXE: begin
          ALUOp = r_aluop;
          ASel  = r_asel;
          BSel  = r_bsel;
          EXTOp = r_extop;
          unique case (r_cls)
            C_ALUR, C_ALUI: w_next = S_WB;
            C_LW, C_SW:     w_next = S_MEM;
            C_BEQ: begin
              PCWr       = Zero;
              NPCOp      = NPC_BR;
              instr_done = 1'b1;
            end
            C_J: begin
              PCWr       = 1'b1;
              NPCOp      = NPC_J;
              instr_done = 1'b1;
            end
            C_JR: begin
              PCWr       = 1'b1;
              NPCOp      = NPC_JR;
              instr_done = 1'b1;
            end
            C_JAL: begin
              PCWr       = 1'b1;
              NPCOp      = NPC_J;
              RFWr       = 1'b1;
              GPRSel     = GPR_R31;
              WDSel      = WD_PC;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          ALUOp = r_aluop;
          ASel  = r_asel;
          BSel  = r_bsel;
          EXTOp = r_extop;
          if (r_cls == C_SW) begin
            DMWr       = 1'b1;
            instr_done = mem_ready;
            w_next     = mem_ready ? S_FETCH : S_MEM;
          end else if (r_cls == C_LW) begin
            w_next = mem_ready ? S_WB : S_MEM;
          end
        end
        S_WB: begin
          ALUOp      = r_aluop;
          ASel       = r_asel;
          BSel       = r_bsel;
          EXTOp      = r_extop;
          RFWr       = 1'b1;
          instr_done = 1'b1;
          GPRSel     = (r_cls == C_ALUR) ? GPR_RD : GPR_RT;
          WDSel      = (r_cls == C_LW) ? WD_DR : WD_C;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed vector bench for mc_sequencer: one table entry
// per clock cycle, plus a reset-during-stall sequence.
module tb_mc_sequencer;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       RFWr, DMWr, PCWr, IRWr;
  logic [1:0] EXTOp, NPCOp, GPRSel, WDSel, ASel;
  logic [4:0] ALUOp;
  logic       BSel;
  logic [2:0] st;
  logic       instr_done, illegal;

  mc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .RFWr       (RFWr),
    .DMWr       (DMWr),
    .PCWr       (PCWr),
    .IRWr       (IRWr),
    .EXTOp      (EXTOp),
    .ALUOp      (ALUOp),
    .NPCOp      (NPCOp),
    .GPRSel     (GPRSel),
    .WDSel      (WDSel),
    .ASel       (ASel),
    .BSel       (BSel),
    .state      (st),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [24:0] w_act;
  assign w_act = {RFWr, DMWr, PCWr, IRWr, EXTOp, ALUOp,
                  NPCOp, GPRSel, WDSel, ASel, BSel, st,
                  instr_done, illegal};

  function automatic logic [24:0] ev(
    input logic rf, dm, pc, ir,
    input logic [1:0] ext, input logic [4:0] alu,
    input logic [1:0] npc, gpr, wd, as,
    input logic bs, input logic [2:0] s,
    input logic dn, il);
    return {rf, dm, pc, ir, ext, alu, npc, gpr, wd,
            as, bs, s, dn, il};
  endfunction

  function automatic logic [24:0] idle(input logic [2:0] s);
    return ev(0,0,0,0,2'd0,5'd0,2'd0,2'd0,2'd0,2'd0,0,s,0,0);
  endfunction

  function automatic logic [24:0] fe();
    return ev(0,0,1,1,2'd0,5'd0,2'd0,2'd0,2'd0,2'd0,0,3'd0,0,0);
  endfunction

  task automatic add(input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [24:0] e);
    vec_t v;
    v = '{rst: r, op: op, fn: fn, z: z, rdy: rdy, exp: e};
    tbl.push_back(v);
  endtask

  task automatic fd(input logic [5:0] op, input logic [5:0] fn);
    add(1, op, fn, 0, 1, fe());
    add(1, op, fn, 0, 1, idle(3'd1));
  endtask

  task automatic alu4(input logic [5:0] op, input logic [5:0] fn,
                      input logic [1:0] ext, input logic [4:0] a,
                      input logic [1:0] gpr, input logic [1:0] as,
                      input logic bs);
    fd(op, fn);
    add(1, op, fn, 0, 1, ev(0,0,0,0,ext,a,2'd0,2'd0,2'd0,as,bs,3'd2,0,0));
    add(1, op, fn, 0, 1, ev(1,0,0,0,ext,a,2'd0,gpr,2'd0,as,bs,3'd4,1,0));
  endtask

  task automatic step(input vec_t v);
    rst       = v.rst;
    Op        = v.op;
    Funct     = v.fn;
    Zero      = v.z;
    mem_ready = v.rdy;
    @(negedge clk);
    n_vec++;
    if (w_act !== v.exp) begin
      n_bad++;
      $display("FAIL vec %0d: outputs %h, expected %h",
               n_vec, w_act, v.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;

    add(0, 6'h00, 6'h00, 0, 1, idle(3'd0));
    add(0, 6'h00, 6'h21, 0, 1, idle(3'd0));
    // R-type and I-type ALU instructions
    alu4(6'b000000, 6'b100001, 2'b00, ALU_ADDU, 2'b00, 2'b00, 0);
    alu4(6'b000000, 6'b100011, 2'b00, ALU_SUBU, 2'b00, 2'b00, 0);
    alu4(6'b000000, 6'b100100, 2'b00, ALU_AND,  2'b00, 2'b00, 0);
    alu4(6'b000000, 6'b101010, 2'b00, ALU_SLT,  2'b00, 2'b00, 0);
    alu4(6'b000000, 6'b000000, 2'b00, ALU_SLL,  2'b00, 2'b10, 0);
    alu4(6'b000000, 6'b000010, 2'b00, ALU_SRL,  2'b00, 2'b10, 0);
    alu4(6'b001001, 6'b001000, 2'b01, ALU_ADDU, 2'b01, 2'b00, 1);
    alu4(6'b001101, 6'b001000, 2'b00, ALU_OR,   2'b01, 2'b00, 1);
    alu4(6'b001111, 6'b001000, 2'b00, ALU_SLL,  2'b01, 2'b01, 1);
    // lw with two stalled MEM cycles: 7 cycles total
    fd(6'b100011, 6'h00);
    add(1, 6'b100011, 6'h00, 0, 1,
        ev(0,0,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd2,0,0));
    add(1, 6'b100011, 6'h00, 0, 0,
        ev(0,0,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd3,0,0));
    add(1, 6'b100011, 6'h00, 0, 0,
        ev(0,0,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd3,0,0));
    add(1, 6'b100011, 6'h00, 0, 1,
        ev(0,0,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd3,0,0));
    add(1, 6'b100011, 6'h00, 0, 1,
        ev(1,0,0,0,2'b01,ALU_ADDU,2'd0,2'b01,2'b01,2'd0,1,3'd4,1,0));
    // sw with one stalled MEM cycle
    fd(6'b101011, 6'h00);
    add(1, 6'b101011, 6'h00, 0, 1,
        ev(0,0,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd2,0,0));
    add(1, 6'b101011, 6'h00, 0, 0,
        ev(0,1,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd3,0,0));
    add(1, 6'b101011, 6'h00, 0, 1,
        ev(0,1,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd3,1,0));
    // beq taken / not taken
    fd(6'b000100, 6'h00);
    add(1, 6'b000100, 6'h00, 1, 1,
        ev(0,0,1,0,2'b01,ALU_SUBU,2'b01,2'd0,2'd0,2'd0,0,3'd2,1,0));
    fd(6'b000100, 6'h00);
    add(1, 6'b000100, 6'h00, 0, 1,
        ev(0,0,0,0,2'b01,ALU_SUBU,2'b01,2'd0,2'd0,2'd0,0,3'd2,1,0));
    // j, jr, jal
    fd(6'b000010, 6'h00);
    add(1, 6'b000010, 6'h00, 0, 1,
        ev(0,0,1,0,2'd0,5'd0,2'b10,2'd0,2'd0,2'd0,0,3'd2,1,0));
    fd(6'b000000, 6'b001000);
    add(1, 6'b000000, 6'b001000, 0, 1,
        ev(0,0,1,0,2'd0,5'd0,2'b11,2'd0,2'd0,2'd0,0,3'd2,1,0));
    fd(6'b000011, 6'h00);
    add(1, 6'b000011, 6'h00, 0, 1,
        ev(1,0,1,0,2'd0,5'd0,2'b10,2'b10,2'b10,2'd0,0,3'd2,1,0));
    // illegal opcode and illegal funct, then a stalled fetch
    add(1, 6'b111111, 6'h00, 0, 1, fe());
    add(1, 6'b111111, 6'h00, 0, 1,
        ev(0,0,0,0,2'd0,5'd0,2'd0,2'd0,2'd0,2'd0,0,3'd1,0,1));
    add(1, 6'b000000, 6'b111111, 0, 1, fe());
    add(1, 6'b000000, 6'b111111, 0, 1,
        ev(0,0,0,0,2'd0,5'd0,2'd0,2'd0,2'd0,2'd0,0,3'd1,0,1));
    add(1, 6'b000000, 6'b100101, 0, 0, idle(3'd0));
    alu4(6'b000000, 6'b100101, 2'b00, ALU_OR, 2'b00, 2'b00, 0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) step(tbl[i]);

    // reset held 3 cycles while sw is stalled in MEM
    tbl.delete();
    fd(6'b101011, 6'h00);
    add(1, 6'b101011, 6'h00, 0, 1,
        ev(0,0,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd2,0,0));
    add(1, 6'b101011, 6'h00, 0, 0,
        ev(0,1,0,0,2'b01,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,1,3'd3,0,0));
    add(0, 6'b101011, 6'h00, 0, 0, idle(3'd3));
    add(0, 6'b101011, 6'h00, 0, 0, idle(3'd0));
    add(0, 6'b101011, 6'h00, 0, 1, idle(3'd0));
    add(1, 6'b101011, 6'h00, 0, 0, idle(3'd0));
    fd(6'b000000, 6'b100001);
    add(1, 6'b000000, 6'b100001, 0, 1,
        ev(0,0,0,0,2'd0,ALU_ADDU,2'd0,2'd0,2'd0,2'd0,0,3'd2,0,0));
    foreach (tbl[i]) step(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
